// File: rtl/uart_buffered_transmitter.sv
// Buffered 8N1 UART transmitter: a power-of-two byte FIFO feeding a
// START/DATA/STOP serialiser that chains frames with no idle gap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line high, waiting for a byte in the FIFO
// ST_START | start bit (low) for SYMBOL cycles
// ST_DATA  | 8 data bits, LSB first, SYMBOL cycles each
// ST_STOP  | stop bit (high) for SYMBOL cycles, then chain or go idle
module uart_buffered_transmitter #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic [7:0]                    DataIn,
   input  logic                          DataInValid,
   output logic                          DataInReady,
   output logic                          SOut,
   output logic                          Busy,
   output logic [$clog2(FIFO_DEPTH):0]   Count
);

   localparam int SYMBOL = CLOCK_FREQ / BAUD_RATE;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int CW     = AW + 1;
   localparam int BW     = (SYMBOL > 2) ? $clog2(SYMBOL) : 1;

   localparam logic [BW-1:0] BAUD_LAST = BW'(SYMBOL - 1);
   localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

   if (SYMBOL < 2) begin : g_bad_symbol
      $error("uart_buffered_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_buffered_transmitter: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [7:0]      mem_d [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            sout_q, sout_d;

   logic            push;
   logic            pop;
   logic            baud_done;
   logic            fifo_nonempty;

   assign baud_done     = (baud_q == BAUD_LAST);
   assign fifo_nonempty = (count_q != '0);
   assign DataInReady   = (count_q != FULL) && !Reset;
   assign push          = DataInValid && DataInReady;
   // Pops happen only from IDLE or at the last cycle of STOP, which is what
   // lets back-to-back frames abut without an idle cycle.
   assign pop           = fifo_nonempty &&
                          ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_done));

   assign SOut  = sout_q;
   assign Busy  = (state_q != ST_IDLE);
   assign Count = count_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         baud_q    <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         sout_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         baud_q    <= baud_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         sout_q    <= sout_d;
      end
   end

   // Storage needs no reset: occupancy and pointers define what is valid.
   always_ff @(posedge Clock) begin
      mem_q <= mem_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (fifo_nonempty) state_d = ST_START;
         ST_START: if (baud_done) state_d = ST_DATA;
         ST_DATA:  if (baud_done && (bit_cnt_q == 3'd7)) state_d = ST_STOP;
         ST_STOP:  if (baud_done) state_d = fifo_nonempty ? ST_START : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = DataIn;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      // Every state or bit boundary coincides with baud_done, so clearing
      // there covers all transitions; IDLE keeps the counter parked at zero.
      if ((state_q == ST_IDLE) || baud_done) begin
         baud_d = '0;
      end else begin
         baud_d = baud_q + BW'(1);
      end

      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      if (pop) begin
         bit_cnt_d = '0;
         shift_d   = mem_q[rd_ptr_q];
      end else if ((state_q == ST_DATA) && baud_done) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
         shift_d   = {1'b0, shift_q[7:1]};
      end

      // Line level is registered from the next state so SOut changes on the
      // same edge as the state it belongs to.
      unique case (state_d)
         ST_START: sout_d = 1'b0;
         ST_DATA:  sout_d = shift_d[0];
         default:  sout_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_buffered_transmitter.sv
// Directed bench for uart_buffered_transmitter at SYMBOL=4, FIFO_DEPTH=8,
// with a line-level receiver model that decodes every frame on SOut.
module tb_uart_buffered_transmitter;

   logic        Clock;
   logic        Reset;
   logic [7:0]  DataIn;
   logic        DataInValid;
   logic        DataInReady;
   logic        SOut;
   logic        Busy;
   logic [3:0]  Count;

   int checks = 0;
   int errors = 0;

   uart_buffered_transmitter #(
      .CLOCK_FREQ (400),
      .BAUD_RATE  (100),
      .FIFO_DEPTH (8)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .DataIn      (DataIn),
      .DataInValid (DataInValid),
      .DataInReady (DataInReady),
      .SOut        (SOut),
      .Busy        (Busy),
      .Count       (Count)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Receiver model: frame cycle 0 is the first negedge with SOut low,
   // data bit j is sampled mid-symbol at cycle 4*j+6, stop at cycle 38.
   logic [7:0] rx_q[$];
   logic       rx_busy = 1'b0;
   int         rx_cnt  = 0;
   logic [7:0] rx_sh   = 8'h00;

   always @(negedge Clock) begin
      if (!rx_busy) begin
         if (SOut === 1'b0) begin
            rx_busy <= 1'b1;
            rx_cnt  <= 0;
         end
      end else begin
         rx_cnt <= rx_cnt + 1;
         if ((rx_cnt + 1) >= 6 && (rx_cnt + 1) <= 34 && ((rx_cnt + 1) % 4) == 2)
            rx_sh <= {SOut, rx_sh[7:1]};
         if ((rx_cnt + 1) == 38) begin
            chk("rx_stop_bit", 32'(SOut), 32'd1);
            rx_q.push_back(rx_sh);
            rx_busy <= 1'b0;
         end
      end
   end

   // Caller must be at the negedge right after the pop edge; returns at the
   // negedge 40 cycles later.
   task automatic expect_frame(input logic [7:0] b, input string tag);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 40; i++) begin
         chk({tag, "_sout"}, 32'(SOut), 32'(f[i/4]));
         chk({tag, "_busy"}, 32'(Busy), 32'd1);
         @(negedge Clock);
      end
   endtask

   task automatic wait_rx(input int n, input int budget);
      for (int t = 0; t < budget && rx_q.size() < n; t++) @(negedge Clock);
   endtask

   task automatic wait_idle(input int budget);
      for (int t = 0; t < budget && Busy !== 1'b0; t++) @(negedge Clock);
   endtask

   initial begin
      int   expc;
      int   lows;
      logic [7:0] exp3 [3];

      // Reset held with a write presented
      Reset       = 1'b1;
      DataInValid = 1'b1;
      DataIn      = 8'h3C;
      repeat (3) @(negedge Clock);
      chk("rst_ready", 32'(DataInReady), 32'd0);
      chk("rst_count", 32'(Count), 32'd0);
      chk("rst_sout",  32'(SOut), 32'd1);
      chk("rst_busy",  32'(Busy), 32'd0);
      Reset       = 1'b0;
      DataInValid = 1'b0;
      @(negedge Clock);
      chk("post_rst_ready", 32'(DataInReady), 32'd1);
      chk("post_rst_count", 32'(Count), 32'd0);
      chk("post_rst_busy",  32'(Busy), 32'd0);

      // Single byte 0xA5 from idle
      rx_q.delete();
      DataIn      = 8'hA5;
      DataInValid = 1'b1;
      @(negedge Clock);
      DataInValid = 1'b0;
      chk("a5_count_after_write", 32'(Count), 32'd1);
      chk("a5_sout_before_pop",   32'(SOut), 32'd1);
      @(negedge Clock);
      chk("a5_count_after_pop", 32'(Count), 32'd0);
      expect_frame(8'hA5, "a5");
      chk("a5_end_busy",  32'(Busy), 32'd0);
      chk("a5_end_sout",  32'(SOut), 32'd1);
      chk("a5_end_count", 32'(Count), 32'd0);
      chk("a5_rx_n", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() >= 1) chk("a5_rx_byte", 32'(rx_q[0]), 32'hA5);

      // 0x00 then 0xFF back to back
      repeat (3) @(negedge Clock);
      rx_q.delete();
      DataIn      = 8'h00;
      DataInValid = 1'b1;
      @(negedge Clock);
      chk("b2b_count1", 32'(Count), 32'd1);
      DataIn = 8'hFF;
      @(negedge Clock);
      DataInValid = 1'b0;
      chk("b2b_count_pop_push", 32'(Count), 32'd1);
      expect_frame(8'h00, "b2b_f0");
      expect_frame(8'hFF, "b2b_f1");
      chk("b2b_end_busy",  32'(Busy), 32'd0);
      chk("b2b_end_count", 32'(Count), 32'd0);

      // Valid held 12 cycles: 9 accepted, FIFO fills at 8
      repeat (3) @(negedge Clock);
      rx_q.delete();
      DataInValid = 1'b1;
      for (int j = 0; j < 12; j++) begin
         DataIn = 8'(8'h30 + j);
         @(negedge Clock);
         expc = (j == 0) ? 1 : ((j > 8) ? 8 : j);
         chk("fill_count", 32'(Count), 32'(expc));
         chk("fill_ready", 32'(DataInReady), (expc != 8) ? 32'd1 : 32'd0);
      end
      DataInValid = 1'b0;
      wait_rx(9, 500);
      chk("fill_rx_n", 32'(rx_q.size()), 32'd9);
      for (int i = 0; i < 9; i++)
         if (i < rx_q.size()) chk("fill_rx_byte", 32'(rx_q[i]), 32'(8'h30 + i));
      wait_idle(20);
      chk("fill_end_busy",  32'(Busy), 32'd0);
      chk("fill_end_count", 32'(Count), 32'd0);

      // Count=1 with a write landing on the STOP-end pop edge
      repeat (3) @(negedge Clock);
      rx_q.delete();
      exp3 = '{8'h5A, 8'hC3, 8'h96};
      DataIn      = exp3[0];
      DataInValid = 1'b1;
      @(negedge Clock);
      DataInValid = 1'b0;
      @(negedge Clock);
      DataIn      = exp3[1];
      DataInValid = 1'b1;
      @(negedge Clock);
      DataInValid = 1'b0;
      chk("pp_count_queued", 32'(Count), 32'd1);
      repeat (38) @(negedge Clock);
      chk("pp_sout_stop", 32'(SOut), 32'd1);
      chk("pp_count_pre", 32'(Count), 32'd1);
      DataIn      = exp3[2];
      DataInValid = 1'b1;
      @(negedge Clock);
      DataInValid = 1'b0;
      chk("pp_count_same", 32'(Count), 32'd1);
      chk("pp_sout_start", 32'(SOut), 32'd0);
      chk("pp_busy",       32'(Busy), 32'd1);
      wait_rx(3, 200);
      chk("pp_rx_n", 32'(rx_q.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         if (i < rx_q.size()) chk("pp_rx_byte", 32'(rx_q[i]), 32'(exp3[i]));
      wait_idle(20);
      chk("pp_end_busy", 32'(Busy), 32'd0);

      // Reset during data bit 3 with 3 bytes queued
      repeat (3) @(negedge Clock);
      DataInValid = 1'b1;
      for (int j = 0; j < 4; j++) begin
         DataIn = 8'(8'hB0 + j);
         @(negedge Clock);
      end
      DataInValid = 1'b0;
      chk("mid_count_queued", 32'(Count), 32'd3);
      repeat (15) @(negedge Clock);
      chk("mid_sout_bit3", 32'(SOut), 32'd0);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      chk("mid_rst_sout",  32'(SOut), 32'd1);
      chk("mid_rst_busy",  32'(Busy), 32'd0);
      chk("mid_rst_count", 32'(Count), 32'd0);
      lows = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge Clock);
         if (SOut !== 1'b1 || Busy !== 1'b0) lows++;
      end
      chk("mid_quiet_line", 32'(lows), 32'd0);
      chk("mid_quiet_count", 32'(Count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
